// File: rtl/lc3_mem_ctrl_pkg.sv
// lc3_mem_pkg: shared state encoding, bus width and counter sizing for the LC-3 memory controller.
package lc3_mem_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_t;
    localparam int MEM_W = 16;
    function automatic int cnt_width(input int wait_cycles);
        return (wait_cycles <= 15) ? 4 : $clog2(wait_cycles + 1);
    endfunction
endpackage

// File: rtl/lc3_mem_ctrl_if.sv
// lc3_mem_ctrl_if: datapath-side and SRAM-side signals of the memory controller.
interface lc3_mem_ctrl_if;
    import lc3_mem_pkg::*;
    logic [MEM_W-1:0] bus;
    logic             ld_mar;
    logic             ld_mdr;
    logic             mio_en;
    logic             mem_req;
    logic             mem_wr;
    logic [MEM_W-1:0] mar_q;
    logic [MEM_W-1:0] mdr_q;
    logic             busy;
    logic             mem_done;
    logic [MEM_W-1:0] sram_addr;
    logic [MEM_W-1:0] sram_wdata;
    logic [MEM_W-1:0] sram_rdata;
    logic             sram_ce_n;
    logic             sram_oe_n;
    logic             sram_we_n;
    modport slave (
        input  bus, ld_mar, ld_mdr, mio_en, mem_req, mem_wr, sram_rdata,
        output mar_q, mdr_q, busy, mem_done, sram_addr, sram_wdata, sram_ce_n, sram_oe_n, sram_we_n
    );
    modport master (
        output bus, ld_mar, ld_mdr, mio_en, mem_req, mem_wr, sram_rdata,
        input  mar_q, mdr_q, busy, mem_done, sram_addr, sram_wdata, sram_ce_n, sram_oe_n, sram_we_n
    );
endinterface

// File: rtl/lc3_mem_ctrl_wait_counter.sv
// mem_wait_counter: loadable down-counter that holds at zero and flags it.
module mem_wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else if (i_load) r_cnt <= i_load_val;
        else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: owns MAR/MDR and runs single fixed-latency transactions against an async SRAM.
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input logic             Clk,
    input logic             Reset_n,
    lc3_mem_ctrl_if.slave   mif
);
    localparam int CW = cnt_width(WAIT_CYCLES);
    mem_state_t       r_state, w_next;
    logic [MEM_W-1:0] r_mar, r_mdr;
    logic             r_wr, r_ce_n, r_oe_n, r_we_n;
    logic             w_zero, w_start, w_final, w_wr, w_idle;
    assign w_idle  = (r_state == IDLE);
    assign w_start = w_idle && mif.mem_req;
    assign w_final = (r_state == ACCESS) && w_zero;
    assign w_wr    = w_start ? mif.mem_wr : r_wr;
    mem_wait_counter #(.W(CW)) u_wait (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .i_load     (w_start),
        .i_load_val (CW'(WAIT_CYCLES - 1)),
        .i_dec      (r_state == ACCESS),
        .o_zero     (w_zero)
    );
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = mif.mem_req ? ACCESS : IDLE;
            ACCESS:  w_next = w_zero ? DONE : ACCESS;
            default: w_next = IDLE;
        endcase
    end
    // Strobes decode the next state so they change cleanly on the clock edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_wr    <= 1'b0;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_wr    <= w_wr;
            r_ce_n  <= (w_next != ACCESS);
            r_oe_n  <= !(w_next == ACCESS && !w_wr);
            r_we_n  <= !(w_next == ACCESS && w_wr);
        end
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_mar <= '0;
            r_mdr <= '0;
        end else begin
            if (w_idle && mif.ld_mar) r_mar <= mif.bus;
            if (w_final && !r_wr) r_mdr <= mif.sram_rdata;
            else if (w_idle && mif.ld_mdr && !mif.mio_en) r_mdr <= mif.bus;
        end
    end
    assign mif.mar_q      = r_mar;
    assign mif.mdr_q      = r_mdr;
    assign mif.busy       = !w_idle;
    assign mif.mem_done   = (r_state == DONE);
    assign mif.sram_addr  = r_mar;
    assign mif.sram_wdata = r_mdr;
    assign mif.sram_ce_n  = r_ce_n;
    assign mif.sram_oe_n  = r_oe_n;
    assign mif.sram_we_n  = r_we_n;
endmodule

// File: doc/lc3_mem_ctrl.md
# lc3_mem_ctrl

Memory-side counterpart to the datapath's load-enabled registers: owns MAR and MDR and runs single read/write transactions against an external asynchronous 16-bit SRAM with a fixed number of wait cycles. Sits between the LC-3 internal bus and the SRAM pins. The control FSM issues single-cycle requests and watches `mem_done`. Read data lands in MDR; write data is taken from MDR.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: SRAM access cycles per transaction; legal range 1..15.

Ports:
- `Clk` in 1: single clock; all state updates on rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `bus` in 16: internal datapath bus.
- `ld_mar` in 1: load MAR from `bus`.
- `ld_mdr` in 1: load MDR from `bus` when `mio_en`=0.
- `mio_en` in 1: 1 means MDR is sourced from memory; blocks `ld_mdr` bus loads.
- `mem_req` in 1: start a transaction; sampled only in IDLE.
- `mem_wr` in 1: transaction type sampled with `mem_req`; 1 is write, 0 is read.
- `mar_q` out 16: current MAR.
- `mdr_q` out 16: current MDR.
- `busy` out 1: high in every non-IDLE state.
- `mem_done` out 1: one-cycle pulse in the DONE state.
- `sram_addr` out 16: SRAM address; equals MAR.
- `sram_wdata` out 16: SRAM write data; equals MDR.
- `sram_rdata` in 16: SRAM read data.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n` out 1 each: active-low SRAM strobes.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - `ld_mar`=1 gives MAR <= `bus`.
  - `ld_mdr`=1 and `mio_en`=0 gives MDR <= `bus`.
  - `mem_req`=1 latches `mem_wr` into an internal `wr_q`, loads the wait counter with WAIT_CYCLES-1, and goes to ACCESS.
  - If `mem_req` and a load are asserted in the same cycle, the load takes effect and the transaction uses the new value.
- ACCESS:
  - Outputs: `sram_ce_n`=0. `sram_oe_n`=0 for a read; `sram_we_n`=0 for a write. The other strobe stays 1.
  - The counter decrements each cycle. When it is 0, go to DONE.
  - On a read, MDR <= `sram_rdata` on that same final edge.
- DONE:
  - Outputs: `mem_done`=1, all strobes 1.
  - Unconditional transition to IDLE.
- While `busy`=1, `ld_mar`, `ld_mdr` and `mem_req` are ignored and MAR/MDR are frozen, except for the read capture.
- `mio_en`=1 with `ld_mdr`=1 in IDLE produces no MDR change.
- Strobes are registered outputs, decoded from the next state, so they are glitch-free.
- No more than one strobe ever goes low alongside `sram_ce_n`.

## Timing
- Reset values: MAR=0, MDR=0, state IDLE, `busy`=0, `mem_done`=0, all strobes 1, `sram_addr`=0, `sram_wdata`=0.
- Reset asserted mid-transaction:
  - Strobes deassert immediately and asynchronously.
  - The FSM returns to IDLE and no `mem_done` is issued.
  - A pending read does not update MDR.
- If `mem_req` is sampled at edge k:
  - ACCESS covers cycles k+1 .. k+WAIT_CYCLES.
  - DONE is cycle k+WAIT_CYCLES+1.
  - IDLE resumes at k+WAIT_CYCLES+2.
- Total latency is WAIT_CYCLES+2 cycles from request to accepting the next request.
- A new `mem_req` in the DONE cycle is ignored; it must be re-asserted in IDLE.
- `sram_addr` and `sram_wdata` are stable for the whole ACCESS window plus DONE.
- For a read, `mdr_q` shows the new data in the DONE cycle.
- `sram_rdata` is sampled only on the final ACCESS edge. Values outside that edge have no effect.
- With WAIT_CYCLES=1, ACCESS lasts exactly one cycle and the counter loads 0.

## Structure
- Package `lc3_mem_pkg`:
  - state enum `mem_state_t` {IDLE, ACCESS, DONE};
  - constant `MEM_W`=16;
  - the counter width function, giving 4 bits for WAIT_CYCLES ≤ 15.
- Sub-module `mem_wait_counter`:
  - a loadable down-counter with load value, decrement enable and `zero` flag;
  - async active-low reset to 0.
- MAR, MDR and the FSM are in the top module.

## Test plan
- Reset: hold `Reset_n`=0 with random inputs. Required: MAR=MDR=0, `busy`=0, `ce_n`/`oe_n`/`we_n`=1/1/1.
- Read, WAIT_CYCLES=2:
  - Stimulus: `bus`=16'h3000 with `ld_mar`; `mem_req`=1, `mem_wr`=0; `sram_rdata`=16'hBEEF.
  - Required: `oe_n`=0 for exactly 2 cycles, `sram_addr`=16'h3000, then `mem_done`=1 for 1 cycle with `mdr_q`=16'hBEEF.
- Write:
  - Stimulus: MAR=16'h4001, MDR=16'h1234 loaded via bus with `mio_en`=0; request with `mem_wr`=1.
  - Required: `we_n`=0 for 2 cycles, `sram_wdata`=16'h1234, `oe_n` stays 1, then `mem_done` pulses.
- Busy lockout:
  - Stimulus: during ACCESS, pulse `ld_mar` with 16'hFFFF and re-assert `mem_req`.
  - Required: MAR unchanged, no second transaction, exactly one `mem_done`.
- `mio_en` block: in IDLE, `mio_en`=1 and `ld_mdr`=1 with `bus`=16'h5555. Required: MDR unchanged.
- Reset mid-read: drop `Reset_n` in the first ACCESS cycle. Required: strobes go to 1 in the same cycle, MDR=0, `mem_done` never asserted.
